// File: rtl/shift_rx_if.sv
// Serial receiver port bundle: serial line, bit strobe and bit order in,
// received word and status pulses out.
// Latency and backpressure are set by shift_rx; this bundle only carries the signals.
// Ports: sin/en/dir (master -> slave), out/valid/frame_err/parity_err/busy (slave -> master).
interface shift_rx_if #(
  parameter int WIDTH = 4
);
  logic             sin;
  logic             en;
  logic             dir;
  logic [WIDTH-1:0] out;
  logic             valid;
  logic             frame_err;
  logic             parity_err;
  logic             busy;

  modport master (
    output sin, en, dir,
    input  out, valid, frame_err, parity_err, busy
  );

  modport slave (
    input  sin, en, dir,
    output out, valid, frame_err, parity_err, busy
  );
endinterface

// File: rtl/shift_rx.sv
// Serial frame receiver: start bit, WIDTH data bits (LSB- or MSB-first), optional even parity, stop bit.
// Latency: out/valid update one cycle after the stop-bit sample; status outputs are single-cycle pulses.
// Backpressure: none; the receiver advances only on en strobes and holds all state while en=0.
// Ports: clk, rst (async active-low), bus (shift_rx_if.slave).
// Optional parity stage is compiled in with macro SHIFT_RX_PARITY_EN.
module shift_rx #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  shift_rx_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SHIFT_RX_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd3
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic               dir_q, dir_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
`ifdef SHIFT_RX_PARITY_EN
  logic               par_q, par_d;        // running XOR of data bits
  logic               perr_pend_q, perr_pend_d; // parity mismatch seen, reported at stop
  logic               perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dir_d   = dir_q;
    out_d   = out_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef SHIFT_RX_PARITY_EN
    par_d       = par_q;
    perr_pend_d = perr_pend_q;
    perr_d      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.en && !bus.sin) begin
          state_d = S_DATA;
          cnt_d   = '0;
          sr_d    = '0;
          // Bit order is frozen here so a dir change mid-frame cannot scramble the word.
          dir_d   = bus.dir;
`ifdef SHIFT_RX_PARITY_EN
          par_d       = 1'b0;
          perr_pend_d = 1'b0;
`endif
        end
      end

      S_DATA: begin
        if (bus.en) begin
          // MSB-first shifts up so the first bit ends in the top position;
          // LSB-first shifts down so the first bit ends in bit 0.
          if (dir_q) sr_d = {sr_q[WIDTH-2:0], bus.sin};
          else       sr_d = {bus.sin, sr_q[WIDTH-1:1]};
`ifdef SHIFT_RX_PARITY_EN
          par_d = par_q ^ bus.sin;
`endif
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_d = '0;
`ifdef SHIFT_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

`ifdef SHIFT_RX_PARITY_EN
      S_PARITY: begin
        if (bus.en) begin
          // Even parity: data bits plus parity bit must XOR to zero.
          perr_pend_d = par_q ^ bus.sin;
          state_d     = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (bus.en) begin
          state_d = S_IDLE;
          ferr_d  = !bus.sin;
`ifdef SHIFT_RX_PARITY_EN
          perr_d = perr_pend_q;
          if (bus.sin && !perr_pend_q) begin
            out_d   = sr_q;
            valid_d = 1'b1;
          end
`else
          if (bus.sin) begin
            out_d   = sr_q;
            valid_d = 1'b1;
          end
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dir_q   <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef SHIFT_RX_PARITY_EN
      par_q       <= 1'b0;
      perr_pend_q <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef SHIFT_RX_PARITY_EN
      par_q       <= par_d;
      perr_pend_q <= perr_pend_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign bus.out       = out_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != S_IDLE);
`ifdef SHIFT_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: doc/shift_rx.md
SHIFT_RX -- requirements
Module: shift_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of data bits per frame (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port sin, input, 1 bit: serial data line, idle high.
REQ-005 SHALL have port en, input, 1 bit: bit strobe; sin is sampled only on cycles with en=1.
REQ-006 SHALL have port dir, input, 1 bit: bit order, 0 = LSB-first, 1 = MSB-first.
REQ-007 SHALL have port out, output, WIDTH bits: last good received word.
REQ-008 SHALL have port valid, output, 1 bit: one-cycle pulse when out is updated.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port parity_err, output, 1 bit: one-cycle pulse on a parity mismatch.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL implement the FSM IDLE -> DATA -> (PARITY) -> STOP -> IDLE, advancing only on en=1 cycles; with en=0 all state, counter and shift register SHALL hold.
REQ-013 IDLE: en=1 with sin=0 (start bit) SHALL enter DATA, clear the bit counter and latch dir; en=1 with sin=1 SHALL stay in IDLE.
REQ-014 DATA: each en=1 cycle SHALL shift sin into the shift register and increment the counter; after the WIDTH-th bit the FSM SHALL go to PARITY if compiled in, else to STOP.
REQ-015 LSB-first SHALL place the first data bit in out[0]; MSB-first SHALL place it in out[WIDTH-1].
REQ-016 A dir change mid-frame SHALL have no effect until the next start bit.
REQ-017 STOP, en=1, sin=1, no parity error: out SHALL load the shift register and valid SHALL pulse high in the next cycle (one-cycle latency after the stop-bit sample).
REQ-018 STOP, en=1, sin=0: frame_err SHALL pulse for one cycle, out SHALL hold and valid SHALL stay low.
REQ-019 After STOP the FSM SHALL return to IDLE; a start bit SHALL be accepted on the first en=1 cycle in IDLE.
REQ-020 valid, frame_err and parity_err SHALL never be high for more than one consecutive cycle.
REQ-021 frame_err and parity_err MAY be high in the same cycle; valid SHALL be low whenever either is high.

Reset
REQ-022 With rst=0, the FSM SHALL go to IDLE immediately regardless of clk, with out=0, valid=0, frame_err=0, parity_err=0, busy=0, counter=0 and shift register=0.
REQ-023 A reset mid-frame SHALL discard the partial frame; out SHALL read 0 after reset.

Configuration
REQ-024 Macro SHIFT_RX_PARITY_EN defined: a PARITY state SHALL sample one even-parity bit after the data bits; a mismatch SHALL raise parity_err in the STOP-resolution cycle and block the out update and valid.
REQ-025 Macro undefined: no PARITY state SHALL exist, the frame SHALL be start + WIDTH data bits + stop, and parity_err SHALL be tied to 0.

Verification
REQ-026 WIDTH=4, dir=0, en=1, no parity, sin stream 0,1,0,1,1,1 -> valid pulse with out=4'b1101.
REQ-027 Same stream with dir=1 -> valid pulse with out=4'b1011.
REQ-028 Stream 0,1,0,1,1 followed by stop bit 0 -> frame_err pulse, valid low, out keeps its prior value.
REQ-029 Same frame as REQ-026 with en=0 inserted for 3 cycles between every bit -> identical result, out=4'b1101, busy high throughout the frame.
REQ-030 rst=0 pulsed after the 2nd data bit, then a full frame 0,0,0,1,1,1 -> out=4'b1100, no stale bits.
REQ-031 With SHIFT_RX_PARITY_EN: data 1,0,1,1 with parity 1 -> out=4'b1101 and valid; with parity 0 -> parity_err pulse, out held.
